// File: rtl/life_grid_engine_if.sv
// Control interface for life_grid_engine: step handshake, row-load port
// and generation status. The controller (buttons / step timer) takes the
// master modport; the engine takes the slave modport.
interface life_grid_engine_if #(
    parameter int ROWS = 8,
    parameter int COLS = 8
);
    logic                    step_req;
    logic                    wrap_mode;
    logic                    load_en;
    logic [$clog2(ROWS)-1:0] load_row;
    logic [COLS-1:0]         load_data;
    logic                    step_busy;
    logic                    step_done;
    logic [15:0]             generation;

    modport master (
        output step_req, wrap_mode, load_en, load_row, load_data,
        input  step_busy, step_done, generation
    );

    modport slave (
        input  step_req, wrap_mode, load_en, load_row, load_data,
        output step_busy, step_done, generation
    );
endinterface

// File: rtl/life_grid_engine.sv
// life_grid_engine: ROWS x COLS Game-of-Life (B3/S23) core with a
// row-multiplexed matrix display. A generation is computed one row per
// cycle into a shadow grid and committed in a single cycle, so the display
// only ever shows complete generations.
// Optional macro LIFE_POPCOUNT_EN adds registered population/extinct outputs.
module life_grid_engine #(
    parameter int                   ROWS       = 8,
    parameter int                   COLS       = 8,
    parameter int                   SCAN_TICKS = 1000,
    parameter logic [ROWS*COLS-1:0] INIT       = 64'h0000_0000_0007_0402
) (
    input  logic                     clk,
    input  logic                     rst,
    life_grid_engine_if.slave        ctl,
    output logic [ROWS-1:0]          rows_out,
    output logic [COLS-1:0]          columns_out
`ifdef LIFE_POPCOUNT_EN
    ,
    output logic [$clog2(ROWS*COLS+1)-1:0] population,
    output logic                           extinct
`endif
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam logic [RW:0] ROW_LIMIT = (RW+1)'(ROWS);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COMPUTE = 2'd1;
    localparam logic [1:0] ST_COMMIT  = 2'd2;

    typedef logic [COLS-1:0] row_t;
    typedef row_t grid_t [ROWS];

    grid_t         grid_q, grid_d;
    grid_t         shadow_q, shadow_d;
    logic [1:0]    state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic          wrap_q, wrap_d;
    logic [15:0]   gen_q, gen_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [RW-1:0] scan_q, scan_d;
    row_t          next_row;
    logic [3:0]    nbr_cnt;

    // Cell lookup with edge handling: dead outside the grid, or toroidal.
    function automatic logic cell_at(input grid_t g, input int r, input int c,
                                     input logic wrap);
        int rr;
        int cc;
        rr = r;
        cc = c;
        if (wrap) begin
            if (rr < 0) rr = rr + ROWS;
            else if (rr >= ROWS) rr = rr - ROWS;
            if (cc < 0) cc = cc + COLS;
            else if (cc >= COLS) cc = cc - COLS;
        end else if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) begin
            return 1'b0;
        end
        return g[RW'(rr)][CW'(cc)];
    endfunction

    // Next-generation contents of the row currently being computed.
    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        next_row = '0;
        nbr_cnt  = '0;
        for (int c = 0; c < COLS; c++) begin
            nbr_cnt = '0;
            for (int dr = -1; dr <= 1; dr++) begin
                for (int dc = -1; dc <= 1; dc++) begin
                    if (dr != 0 || dc != 0) begin
                        nbr_cnt = nbr_cnt +
                                  4'(cell_at(grid_q, int'(row_q) + dr, c + dc, wrap_q));
                    end
                end
            end
            next_row[c] = (nbr_cnt == 4'd3) || (grid_q[row_q][c] && nbr_cnt == 4'd2);
        end
    end

    // Step FSM, row loads, shadow writes and commit.
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        wrap_d   = wrap_q;
        gen_d    = gen_q;
        grid_d   = grid_q;
        shadow_d = shadow_q;
        case (state_q)
            ST_IDLE: begin
                if (ctl.load_en) begin
                    // Load wins over a simultaneous step request.
                    if ({1'b0, ctl.load_row} < ROW_LIMIT) begin
                        grid_d[ctl.load_row] = ctl.load_data;
                    end
                end else if (ctl.step_req) begin
                    wrap_d  = ctl.wrap_mode;
                    row_d   = '0;
                    state_d = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                shadow_d[row_q] = next_row;
                if (row_q == RW'(ROWS - 1)) begin
                    state_d = ST_COMMIT;
                end else begin
                    row_d = row_q + RW'(1);
                end
            end
            ST_COMMIT: begin
                grid_d  = shadow_q;
                gen_d   = gen_q + 16'd1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Free-running display scan, independent of the step FSM.
    always_comb begin
        tick_d = tick_q + TW'(1);
        scan_d = scan_q;
        if (tick_q == TW'(SCAN_TICKS - 1)) begin
            tick_d = '0;
            scan_d = (scan_q == RW'(ROWS - 1)) ? '0 : scan_q + RW'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            wrap_q  <= 1'b0;
            gen_q   <= '0;
            tick_q  <= '0;
            scan_q  <= '0;
            // NOTE: the grids are small flop arrays (not RAM), so they are
            // reset like any other register.
            for (int r = 0; r < ROWS; r++) begin
                grid_q[r]   <= INIT[r*COLS +: COLS];
                shadow_q[r] <= '0;
            end
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            wrap_q   <= wrap_d;
            gen_q    <= gen_d;
            tick_q   <= tick_d;
            scan_q   <= scan_d;
            grid_q   <= grid_d;
            shadow_q <= shadow_d;
        end
    end

    assign ctl.step_busy  = (state_q != ST_IDLE);
    assign ctl.step_done  = (state_q == ST_COMMIT);
    assign ctl.generation = gen_q;
    assign rows_out       = ROWS'(1) << scan_q;
    assign columns_out    = grid_q[scan_q];

`ifdef LIFE_POPCOUNT_EN
    localparam int PW = $clog2(ROWS*COLS+1);

    logic [PW-1:0] population_q, population_d;
    logic          extinct_q, extinct_d;

    // Live-cell count of the committed grid.
    always_comb begin
        population_d = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                population_d = population_d + PW'(grid_q[r][c]);
            end
        end
        extinct_d = (population_d == '0);
    end

    // Population registers, one cycle behind the committed grid.
    always_ff @(posedge clk) begin
        if (rst) begin
            population_q <= PW'($countones(INIT));
            extinct_q    <= (INIT == '0);
        end else begin
            population_q <= population_d;
            extinct_q    <= extinct_d;
        end
    end

    assign population = population_q;
    assign extinct    = extinct_q;
`endif
endmodule

// File: tb/tb_life_grid_engine.sv
// Self-checking bench for life_grid_engine (8x8, SCAN_TICKS=1) against a
// whole-grid Game-of-Life reference model.
module tb_life_grid_engine;
    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam logic [63:0] INIT = 64'h0000_0000_0007_0402;

    logic            clk = 1'b0;
    logic            rst;
    logic [ROWS-1:0] rows_out;
    logic [COLS-1:0] columns_out;
`ifdef LIFE_POPCOUNT_EN
    logic [$clog2(ROWS*COLS+1)-1:0] population;
    logic                           extinct;
`endif

    int total = 0;
    int bad   = 0;

    bit              m [ROWS][COLS];
    int              m_gen;
    logic [COLS-1:0] cap [ROWS];
    bit              cap_ok;

    life_grid_engine_if #(.ROWS(ROWS), .COLS(COLS)) ifc ();

    life_grid_engine #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_TICKS(1), .INIT(INIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ctl         (ifc),
        .rows_out    (rows_out),
        .columns_out (columns_out)
`ifdef LIFE_POPCOUNT_EN
        ,
        .population  (population),
        .extinct     (extinct)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    task automatic model_reset();
        logic [63:0] v;
        v = INIT;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                m[r][c] = v[r*COLS + c];
        m_gen = 0;
    endtask

    task automatic model_step(input bit wrap);
        bit nx [ROWS][COLS];
        int n, rr, cc;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr == 0 && dc == 0) continue;
                        rr = r + dr;
                        cc = c + dc;
                        if (wrap) begin
                            rr = (rr + ROWS) % ROWS;
                            cc = (cc + COLS) % COLS;
                        end else if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) begin
                            continue;
                        end
                        n += int'(m[rr][cc]);
                    end
                end
                nx[r][c] = (n == 3) || (m[r][c] && n == 2);
            end
        end
        m = nx;
        m_gen = (m_gen + 1) % 65536;
    endtask

    function automatic logic [COLS-1:0] model_row(input int r);
        logic [COLS-1:0] v;
        for (int c = 0; c < COLS; c++) v[c] = m[r][c];
        return v;
    endfunction

    function automatic int model_pop();
        int p = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                p += int'(m[r][c]);
        return p;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic apply_reset();
        rst = 1'b1;
        ifc.step_req  = 1'b0;
        ifc.wrap_mode = 1'b0;
        ifc.load_en   = 1'b0;
        ifc.load_row  = '0;
        ifc.load_data = '0;
        tick();
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic load_row(input int r, input logic [COLS-1:0] d);
        ifc.load_en   = 1'b1;
        ifc.load_row  = 3'(r);
        ifc.load_data = d;
        tick();
        ifc.load_en = 1'b0;
        for (int c = 0; c < COLS; c++) m[r][c] = d[c];
    endtask

    // Issues one step; lat = cycles from acceptance to step_done (-1 on timeout).
    // Returns one cycle after step_done so the new grid is committed.
    task automatic do_step(input bit wrap, output int lat);
        ifc.step_req  = 1'b1;
        ifc.wrap_mode = wrap;
        tick();
        ifc.step_req  = 1'b0;
        ifc.wrap_mode = ~wrap;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            if (ifc.step_done) begin
                lat = n;
                break;
            end
            tick();
        end
        tick();
        model_step(wrap);
    endtask

    // Watches one full scan and records each row's displayed contents.
    task automatic capture_grid();
        int idx;
        cap_ok = 1'b1;
        for (int r = 0; r < ROWS; r++) cap[r] = 'x;
        for (int i = 0; i < ROWS; i++) begin
            idx = -1;
            if ($onehot(rows_out)) begin
                for (int j = 0; j < ROWS; j++) if (rows_out[j]) idx = j;
            end
            if (idx < 0) cap_ok = 1'b0;
            else cap[idx] = columns_out;
            tick();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [63:0] v;
        int er;
        v = INIT;
        apply_reset();
        total++; if (rows_out !== 8'h01) begin bad++; $display("FAIL reset_rows got=%h exp=01", rows_out); end
        total++; if (columns_out !== v[7:0]) begin bad++; $display("FAIL reset_cols got=%h exp=%h", columns_out, v[7:0]); end
        total++; if (ifc.generation !== 16'd0) begin bad++; $display("FAIL reset_gen got=%0d exp=0", ifc.generation); end
        total++; if (ifc.step_busy !== 1'b0 || ifc.step_done !== 1'b0) begin
            bad++; $display("FAIL reset_flags busy=%b done=%b exp=0,0", ifc.step_busy, ifc.step_done);
        end
        for (int k = 1; k <= ROWS; k++) begin
            tick();
            er = k % ROWS;
            total++;
            if (rows_out !== 8'(1 << er) || columns_out !== v[er*COLS +: COLS]) begin
                bad++;
                $display("FAIL reset_scan k=%0d got rows=%h cols=%h exp rows=%h cols=%h",
                         k, rows_out, columns_out, 8'(1 << er), v[er*COLS +: COLS]);
            end
        end
    endtask

    task automatic test_blinker();
        int lat;
        for (int r = 0; r < ROWS; r++) load_row(r, '0);
        load_row(3, 8'h1C);
        for (int g = 1; g <= 2; g++) begin
            do_step(1'b0, lat);
            total++; if (lat != ROWS + 1) begin bad++; $display("FAIL blinker_latency g=%0d got=%0d exp=%0d", g, lat, ROWS + 1); end
            total++; if (ifc.generation !== 16'(m_gen)) begin bad++; $display("FAIL blinker_gen got=%0d exp=%0d", ifc.generation, m_gen); end
            capture_grid();
            total++; if (!cap_ok) begin bad++; $display("FAIL blinker_onehot g=%0d got=not-onehot exp=onehot", g); end
            for (int r = 0; r < ROWS; r++) begin
                total++;
                if (cap[r] !== model_row(r)) begin bad++; $display("FAIL blinker_row g=%0d r=%0d got=%h exp=%h", g, r, cap[r], model_row(r)); end
            end
        end
    endtask

    task automatic test_edge_mode();
        int lat;
        for (int pass = 0; pass < 2; pass++) begin
            for (int r = 0; r < ROWS; r++) load_row(r, (r == 7 || r == 0 || r == 1) ? 8'h08 : 8'h00);
            do_step(pass == 0, lat);
            total++; if (lat != ROWS + 1) begin bad++; $display("FAIL edge_latency wrap=%0d got=%0d exp=%0d", pass == 0, lat, ROWS + 1); end
            capture_grid();
            for (int r = 0; r < ROWS; r++) begin
                total++;
                if (cap[r] !== model_row(r)) begin bad++; $display("FAIL edge_row wrap=%0d r=%0d got=%h exp=%h", pass == 0, r, cap[r], model_row(r)); end
            end
        end
    endtask

    task automatic test_glider_torus();
        int lat;
        int late = 0;
        logic [63:0] v;
        v = INIT;
        apply_reset();
        for (int s = 0; s < 32; s++) begin
            do_step(1'b1, lat);
            if (lat != ROWS + 1) late++;
        end
        total++; if (late != 0) begin bad++; $display("FAIL glider_latency got=%0d bad-latency steps exp=0", late); end
        total++; if (ifc.generation !== 16'd32) begin bad++; $display("FAIL glider_gen got=%0d exp=32", ifc.generation); end
        capture_grid();
        for (int r = 0; r < ROWS; r++) begin
            total++;
            if (cap[r] !== v[r*COLS +: COLS]) begin bad++; $display("FAIL glider_row r=%0d got=%h exp=%h", r, cap[r], v[r*COLS +: COLS]); end
        end
    endtask

    task automatic test_random();
        int lat;
        bit wrap;
        for (int it = 0; it < 4; it++) begin
            for (int r = 0; r < ROWS; r++) load_row(r, 8'($urandom));
            wrap = 1'($urandom_range(0, 1));
            for (int s = 0; s < 3; s++) begin
                do_step(wrap, lat);
                total++; if (lat != ROWS + 1) begin bad++; $display("FAIL random_latency it=%0d got=%0d exp=%0d", it, lat, ROWS + 1); end
                total++; if (ifc.generation !== 16'(m_gen)) begin bad++; $display("FAIL random_gen got=%0d exp=%0d", ifc.generation, m_gen); end
                capture_grid();
                for (int r = 0; r < ROWS; r++) begin
                    total++;
                    if (cap[r] !== model_row(r)) begin bad++; $display("FAIL random_row it=%0d s=%0d r=%0d got=%h exp=%h", it, s, r, cap[r], model_row(r)); end
                end
`ifdef LIFE_POPCOUNT_EN
                total++;
                if (int'(population) != model_pop() || extinct !== (model_pop() == 0)) begin
                    bad++; $display("FAIL random_pop got=%0d/%b exp=%0d/%b", population, extinct, model_pop(), model_pop() == 0);
                end
`endif
            end
        end
    endtask

    task automatic test_collisions();
        int dones = 0;
        int r;
        logic [COLS-1:0] d;
        // Step and load requests during COMPUTE are dropped.
        ifc.step_req  = 1'b1;
        ifc.wrap_mode = 1'b1;
        tick();
        ifc.step_req = 1'b0;
        if (ifc.step_done) dones++;
        for (int i = 0; i < 3; i++) begin tick(); if (ifc.step_done) dones++; end
        r = $urandom_range(0, ROWS - 1);
        ifc.load_en   = 1'b1;
        ifc.load_row  = 3'(r);
        ifc.load_data = ~model_row(r);
        ifc.step_req  = 1'b1;
        tick();
        ifc.load_en  = 1'b0;
        ifc.step_req = 1'b0;
        for (int i = 0; i < 40; i++) begin if (ifc.step_done) dones++; tick(); end
        model_step(1'b1);
        total++; if (dones != 1) begin bad++; $display("FAIL busy_collision_dones got=%0d exp=1", dones); end
        total++; if (ifc.generation !== 16'(m_gen)) begin bad++; $display("FAIL busy_collision_gen got=%0d exp=%0d", ifc.generation, m_gen); end
        capture_grid();
        for (int i = 0; i < ROWS; i++) begin
            total++;
            if (cap[i] !== model_row(i)) begin bad++; $display("FAIL busy_collision_row r=%0d got=%h exp=%h", i, cap[i], model_row(i)); end
        end
        // Load and step together in IDLE: load wins, no step.
        r = $urandom_range(0, ROWS - 1);
        d = ~model_row(r);
        ifc.load_en   = 1'b1;
        ifc.load_row  = 3'(r);
        ifc.load_data = d;
        ifc.step_req  = 1'b1;
        tick();
        ifc.load_en  = 1'b0;
        ifc.step_req = 1'b0;
        for (int c = 0; c < COLS; c++) m[r][c] = d[c];
        total++; if (ifc.step_busy !== 1'b0) begin bad++; $display("FAIL idle_collision_busy got=%b exp=0", ifc.step_busy); end
        capture_grid();
        total++; if (ifc.generation !== 16'(m_gen)) begin bad++; $display("FAIL idle_collision_gen got=%0d exp=%0d", ifc.generation, m_gen); end
        for (int i = 0; i < ROWS; i++) begin
            total++;
            if (cap[i] !== model_row(i)) begin bad++; $display("FAIL idle_collision_row r=%0d got=%h exp=%h", i, cap[i], model_row(i)); end
        end
    endtask

    task automatic test_back_to_back();
        int n1 = -1;
        int n2 = -1;
        bit wrap;
        wrap = 1'($urandom_range(0, 1));
        ifc.step_req  = 1'b1;
        ifc.wrap_mode = wrap;
        tick();
        for (int n = 1; n <= 40; n++) begin
            if (ifc.step_done) begin n1 = n; break; end
            tick();
        end
        tick();
        for (int n = 1; n <= 40; n++) begin
            if (ifc.step_done) begin n2 = n; break; end
            tick();
        end
        ifc.step_req = 1'b0;
        total++; if (n1 != ROWS + 1) begin bad++; $display("FAIL b2b_first got=%0d exp=%0d", n1, ROWS + 1); end
        total++; if (n2 != ROWS + 2) begin bad++; $display("FAIL b2b_spacing got=%0d exp=%0d", n2, ROWS + 2); end
        tick();
        tick();
        total++; if (ifc.step_busy !== 1'b0) begin bad++; $display("FAIL b2b_stop_busy got=%b exp=0", ifc.step_busy); end
        model_step(wrap);
        model_step(wrap);
        total++; if (ifc.generation !== 16'(m_gen)) begin bad++; $display("FAIL b2b_gen got=%0d exp=%0d", ifc.generation, m_gen); end
        capture_grid();
        for (int i = 0; i < ROWS; i++) begin
            total++;
            if (cap[i] !== model_row(i)) begin bad++; $display("FAIL b2b_row r=%0d got=%h exp=%h", i, cap[i], model_row(i)); end
        end
    endtask

    task automatic test_reset_mid_step();
        int dones = 0;
        ifc.step_req  = 1'b1;
        ifc.wrap_mode = 1'b1;
        tick();
        ifc.step_req = 1'b0;
        for (int i = 0; i < 3; i++) begin if (ifc.step_done) dones++; tick(); end
        total++; if (ifc.step_busy !== 1'b1) begin bad++; $display("FAIL midreset_busy_before got=%b exp=1", ifc.step_busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        total++; if (ifc.step_busy !== 1'b0 || ifc.step_done !== 1'b0) begin
            bad++; $display("FAIL midreset_flags busy=%b done=%b exp=0,0", ifc.step_busy, ifc.step_done);
        end
        total++; if (ifc.generation !== 16'd0) begin bad++; $display("FAIL midreset_gen got=%0d exp=0", ifc.generation); end
        for (int i = 0; i < 12; i++) begin if (ifc.step_done) dones++; tick(); end
        total++; if (dones != 0) begin bad++; $display("FAIL midreset_dones got=%0d exp=0", dones); end
        capture_grid();
        for (int i = 0; i < ROWS; i++) begin
            total++;
            if (cap[i] !== model_row(i)) begin bad++; $display("FAIL midreset_row r=%0d got=%h exp=%h", i, cap[i], model_row(i)); end
        end
    endtask

    initial begin
        test_reset();
        test_blinker();
        test_edge_mode();
        test_glider_torus();
        test_random();
        test_collisions();
        test_back_to_back();
        test_reset_mid_step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/life_grid_engine.md
Name: life_grid_engine

Overview:
- Parametrised Game-of-Life core for the LED-matrix life design: holds a ROWS x COLS cell grid, computes B3/S23 generations on request and drives a row-multiplexed matrix display.
- Generalises the fixed 8x8 life top: configurable grid size and scan rate, selectable edge mode (dead edges or toroidal), a step handshake, a row-load port and a generation counter.
- Sits between button/step-timing logic and the rows_out/columns_out matrix pins.

Parameters:
- ROWS, 8, grid rows; >= 3.
- COLS, 8, grid columns; >= 3.
- SCAN_TICKS, 1000, clk cycles each display row is held; >= 1.
- INIT, 64'h0000_0000_0007_0402, reset grid contents; width ROWS*COLS; bit r*COLS+c is cell (r,c). Default is a glider.

Ports:
- clk  in  1  system clock; only clock domain.
- rst  in  1  synchronous, active-high reset.
- step_req  in  1  request one generation; sampled in IDLE only.
- wrap_mode  in  1  0 = cells outside grid are dead; 1 = toroidal wrap; sampled when a step is accepted.
- load_en  in  1  write load_data into grid row load_row; IDLE only.
- load_row  in  $clog2(ROWS)  row index for load; values >= ROWS ignored.
- load_data  in  COLS  row contents; bit c = column c.
- step_busy  out  1  high while a generation is in progress.
- step_done  out  1  one-cycle pulse when a generation has been committed.
- generation  out  16  committed generation count.
- rows_out  out  ROWS  one-hot row select, active-high.
- columns_out  out  COLS  committed cell states of the selected row; 1 = alive.

Behaviour:
- Reset: the following values take effect on the clock edge with rst=1:
  - grid = INIT; shadow grid cleared; state IDLE; generation = 0; step_busy = 0; step_done = 0.
  - Scan row = 0 and scan tick counter = 0, so rows_out = 1 and columns_out = INIT row 0.
- Reset mid-step aborts the step: no commit, no step_done.
- FSM IDLE -> COMPUTE -> COMMIT -> IDLE:
  - IDLE:
    - step_req=1 and load_en=0: latch wrap_mode, set compute row = 0, go to COMPUTE.
    - load_en=1: write grid[load_row] and ignore step_req; load has priority.
  - COMPUTE, one row per cycle, rows 0..ROWS-1:
    - next state of every cell in the row is written to the shadow grid, computed from the unmodified committed grid.
    - Neighbour count is 4 bits, range 0..8.
    - Dead edges: out-of-range neighbours count as 0. Toroidal: row and column indices are taken modulo ROWS/COLS.
    - Rule: alive and count in {2,3} -> alive; dead and count == 3 -> alive; otherwise dead.
    - After row ROWS-1, go to COMMIT.
  - COMMIT: grid <= shadow; generation += 1, wrapping 0xFFFF -> 0; step_done = 1 for this single cycle; return to IDLE.
- Timing and collisions:
  - step_busy = 1 in COMPUTE and COMMIT.
  - step_done asserts ROWS+1 cycles after the cycle in which step_req was accepted.
  - New grid is visible on columns_out the cycle after step_done.
  - step_req while busy is ignored, not queued. load_en while busy is ignored.
  - A step_req held high produces back-to-back generations, with one IDLE cycle between them.
- Display:
  - Runs free and independently of the FSM.
  - Tick counter counts 0..SCAN_TICKS-1. On wrap, scan row advances; ROWS-1 wraps to 0.
  - rows_out = 1 << scan_row; columns_out = grid[scan_row], combinational from registers.
  - Only the committed grid is shown, so no tearing during COMPUTE.
  - A load is visible on the next cycle if the loaded row is the one being scanned.

Optional Feature:
- LIFE_POPCOUNT_EN defined:
  - Adds output population, width $clog2(ROWS*COLS+1): live-cell count of the committed grid.
  - Adds output extinct: 1 when population == 0.
  - Both are registered. On reset they take the values for INIT (5 and 0 by default). They update in the cycle after COMMIT or after a load.
- Not defined: these ports and the counting logic are absent; all other behaviour is identical.

Test Plan:
- Reset, defaults, SCAN_TICKS=1:
  - rows_out = 0x01, columns_out = 0x02, generation = 0, step_busy = 0.
  - Following cycles: rows_out 0x02, 0x04, ..., 0x80, 0x01 with columns_out 0x04, 0x07, 0x00, ...
- Blinker:
  - Load all rows to 0, then row 3 = 0x1C; pulse step_req.
  - step_done 9 cycles later; rows 2, 3, 4 = 0x08; generation = 1.
  - A second step restores row 3 = 0x1C with rows 2 and 4 = 0; generation = 2.
- Edge mode: load column 3 set in rows 7, 0, 1 (0x08 each).
  - wrap_mode = 1, step -> row 0 = 0x1C, all other rows 0.
  - Reload, wrap_mode = 0, step -> all rows 0.
- Toroidal glider: from reset, 32 steps with wrap_mode = 1 -> grid equals INIT, generation = 32.
- Collisions:
  - step_req and load_en pulsed during COMPUTE -> ignored; exactly one step_done; generation += 1; grid unaffected by the load.
  - In IDLE, load_en and step_req in the same cycle -> load applied, no step started.
- Reset mid-step: rst asserted on the 4th COMPUTE cycle -> grid = INIT, generation = 0, no step_done, step_busy = 0 the next cycle.
